// File: rtl/gf_point_add_ctrl.sv
// Sequencer for affine elliptic-curve point addition R = P + Q over GF(p).
// Drives an external GFAU through a fixed 9-step microprogram and holds all
// intermediates in local registers; the only local arithmetic is the x1==x2
// compare and the per-operation timeout counter.
module gf_point_add_ctrl #(
    parameter int unsigned TIMEOUT = 1023,
    parameter logic [1:0]  OP_ADD  = 2'b00,
    parameter logic [1:0]  OP_SUB  = 2'b01,
    parameter logic [1:0]  OP_MULT = 2'b10,
    parameter logic [1:0]  OP_DIV  = 2'b11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_x1,
    input  logic [31:0] i_y1,
    input  logic [31:0] i_x2,
    input  logic [31:0] i_y2,
    input  logic [31:0] i_prime,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_x3,
    output logic [31:0] o_y3,
    output logic [31:0] o_in_0,
    output logic [31:0] o_in_1,
    output logic [31:0] o_prime,
    output logic [1:0]  o_op,
    output logic        o_dfc,
    input  logic [31:0] i_gfau_result,
    input  logic        i_gfau_done
);

    localparam int unsigned W         = 32;
    localparam int unsigned CW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  LAST_STEP = 4'd8;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_XEQ  = 2'b01;
    localparam logic [1:0] CODE_TO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_ACK, S_FINISH
    } state_t;

    state_t         state;
    logic [3:0]     step;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   x1_r, y1_r, x2_r, y2_r;
    logic [W-1:0]   t0, t1, lam, t2, t3, x3_r, y3_r;

    logic [3:0]     ld_step;
    logic [W-1:0]   ld_a, ld_b;
    logic [1:0]     ld_op;

    // Operands and opcode of the step about to be issued (step 0 from CHECK, else step+1).
    always_comb begin
        ld_step = (state == S_CHECK) ? 4'd0 : 4'(step + 4'd1);
        ld_a    = '0;
        ld_b    = '0;
        ld_op   = OP_ADD;
        case (ld_step)
            4'd0:    begin ld_a = y2_r; ld_b = y1_r; ld_op = OP_SUB;  end
            4'd1:    begin ld_a = x2_r; ld_b = x1_r; ld_op = OP_SUB;  end
            4'd2:    begin ld_a = t0;   ld_b = t1;   ld_op = OP_DIV;  end
            4'd3:    begin ld_a = lam;  ld_b = lam;  ld_op = OP_MULT; end
            4'd4:    begin ld_a = t2;   ld_b = x1_r; ld_op = OP_SUB;  end
            4'd5:    begin ld_a = t2;   ld_b = x2_r; ld_op = OP_SUB;  end
            4'd6:    begin ld_a = x1_r; ld_b = x3_r; ld_op = OP_SUB;  end
            4'd7:    begin ld_a = lam;  ld_b = t3;   ld_op = OP_MULT; end
            4'd8:    begin ld_a = t3;   ld_b = y1_r; ld_op = OP_SUB;  end
            default: begin ld_a = '0;   ld_b = '0;   ld_op = OP_ADD;  end
        endcase
    end

    // Control FSM, microprogram sequencing and registered GFAU/result outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            step       <= '0;
            cnt        <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            x2_r       <= '0;
            y2_r       <= '0;
            t0         <= '0;
            t1         <= '0;
            lam        <= '0;
            t2         <= '0;
            t3         <= '0;
            x3_r       <= '0;
            y3_r       <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= CODE_NONE;
            o_x3       <= '0;
            o_y3       <= '0;
            o_in_0     <= '0;
            o_in_1     <= '0;
            o_prime    <= '0;
            o_op       <= OP_ADD;
            o_dfc      <= 1'b1;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        x1_r       <= i_x1;
                        y1_r       <= i_y1;
                        x2_r       <= i_x2;
                        y2_r       <= i_y2;
                        o_prime    <= i_prime;
                        o_err_code <= CODE_NONE;
                        o_busy     <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (x1_r == x2_r) begin
                        o_err_code <= CODE_XEQ;
                        o_done     <= 1'b1;
                        o_err      <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        step   <= '0;
                        cnt    <= '0;
                        o_in_0 <= ld_a;
                        o_in_1 <= ld_b;
                        o_op   <= ld_op;
                        o_dfc  <= 1'b0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_gfau_done) begin
                        case (step)
                            4'd0:    t0   <= i_gfau_result;
                            4'd1:    t1   <= i_gfau_result;
                            4'd2:    lam  <= i_gfau_result;
                            4'd3:    t2   <= i_gfau_result;
                            4'd4:    t2   <= i_gfau_result;
                            4'd5:    x3_r <= i_gfau_result;
                            4'd6:    t3   <= i_gfau_result;
                            4'd7:    t3   <= i_gfau_result;
                            default: y3_r <= i_gfau_result;
                        endcase
                        o_dfc <= 1'b1;
                        state <= S_ACK;
                    end else if (cnt + CW'(1) == CW'(TIMEOUT)) begin
                        o_err_code <= CODE_TO;
                        o_done     <= 1'b1;
                        o_err      <= 1'b1;
                        o_dfc      <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ACK: begin
                    if (step == LAST_STEP) begin
                        o_x3       <= x3_r;
                        o_y3       <= y3_r;
                        o_err_code <= CODE_NONE;
                        o_done     <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        step   <= ld_step;
                        cnt    <= '0;
                        o_in_0 <= ld_a;
                        o_in_1 <= ld_b;
                        o_op   <= ld_op;
                        o_dfc  <= 1'b0;
                        state  <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
